// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a small prefetch queue feeding the ID stage.
// One shared single-port memory with one-cycle read latency; MEM-stage data
// accesses take the port ahead of instruction fetch.
// Optional macro IFQ_BYPASS_EN: when defined, a response that arrives while
// the queue is empty and ID is accepting goes straight into the ID registers.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] RsData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        DataRead,
  input  logic        DataWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] DataWData,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_Write,
  input  logic [31:0] Mem_ReadData,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCplus4,
  output logic        ID_Valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      infl_pc4_q, infl_pc4_d;
  logic [31:0]      qinstr_q [DEPTH];
  logic [31:0]      qpc4_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      id_instr_q, id_instr_d, id_pc4_q, id_pc4_d;
  logic             id_valid_q, id_valid_d;

  logic             data_acc, redirect, fetch, resp, bypass, push, pop;
  logic [31:0]      target;
  logic [CNT_W-1:0] occupancy;

  // Port arbitration, fetch eligibility and queue push/pop decisions.
  always_comb begin
    data_acc  = DataRead | DataWrite;
    redirect  = (PCSrc != 2'b00);
    case (PCSrc)
      2'b01:   target = BranchAddr;
      2'b10:   target = JumpAddr;
      default: target = RsData;
    endcase
    // Entries already queued plus the one word still coming back from memory.
    occupancy = count_q + CNT_W'(inflight_q);
    fetch     = !data_acc && !redirect && (occupancy < CNT_W'(DEPTH));
    // A redirect in the response cycle kills the returning word.
    resp      = inflight_q && !redirect;
    bypass    = BYPASS && resp && (count_q == '0) && !Stall && !Flush;
    push      = resp && !bypass;
    pop       = !redirect && !Flush && !Stall && (count_q != '0);

    Mem_Address   = data_acc ? DataAddr : pc_q;
    Mem_WriteData = DataWData;
    Mem_Write     = DataWrite & Reset;
  end

  // Next-state for PC, in-flight tracking, queue pointers and ID registers.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = fetch;
    infl_pc4_d = infl_pc4_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    if (redirect) begin
      pc_d = target;
    end else if (fetch) begin
      pc_d       = pc_q + 32'd4;
      infl_pc4_d = pc_q + 32'd4;
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Redirect and Flush both kill the ID slot; otherwise Stall holds it.
    if (redirect || Flush) begin
      id_valid_d = 1'b0;
    end else if (!Stall) begin
      if (count_q != '0) begin
        id_instr_d = qinstr_q[rd_ptr_q];
        id_pc4_d   = qpc4_q[rd_ptr_q];
        id_valid_d = 1'b1;
      end else if (bypass) begin
        id_instr_d = Mem_ReadData;
        id_pc4_d   = infl_pc4_q;
        id_valid_d = 1'b1;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Queue storage and in-flight PC+4 are pure data, qualified by control.
  always_ff @(posedge Clock) begin
    infl_pc4_q <= infl_pc4_d;
    if (push) begin
      qinstr_q[wr_ptr_q] <= Mem_ReadData;
      qpc4_q[wr_ptr_q]   <= infl_pc4_q;
    end
  end

  assign ID_Instruction = id_instr_q;
  assign ID_PCplus4     = id_pc4_q;
  assign ID_Valid       = id_valid_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: the instruction stream seen at ID must be the
// program-order stream starting at the last reset/redirect target.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam int FIRST_LAT = 2;
`else
  localparam int FIRST_LAT = 3;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] BranchAddr, JumpAddr, RsData;
  logic        Stall, Flush, DataRead, DataWrite;
  logic [31:0] DataAddr, DataWData;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Mem_Write;
  logic [31:0] ID_Instruction, ID_PCplus4;
  logic        ID_Valid;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Reset(Reset), .PCSrc(PCSrc), .BranchAddr(BranchAddr),
    .JumpAddr(JumpAddr), .RsData(RsData), .Stall(Stall), .Flush(Flush),
    .DataRead(DataRead), .DataWrite(DataWrite), .DataAddr(DataAddr),
    .DataWData(DataWData), .Mem_Address(Mem_Address),
    .Mem_WriteData(Mem_WriteData), .Mem_Write(Mem_Write),
    .Mem_ReadData(Mem_ReadData), .ID_Instruction(ID_Instruction),
    .ID_PCplus4(ID_PCplus4), .ID_Valid(ID_Valid)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory: one-cycle read latency.
  logic [31:0] mem [1024];
  logic [31:0] rdata;
  always @(posedge Clock) begin
    if (Mem_Write) mem[Mem_Address[11:2]] = Mem_WriteData;
    rdata <= mem[Mem_Address[11:2]];
  end
  assign Mem_ReadData = rdata;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected program-order addresses still to reach ID.
  logic [31:0] exp_q [$];

  function automatic void restart(input logic [31:0] a);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(a + 32'(4 * k));
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) restart(RESET_PC);
    else if (PCSrc == 2'b01) restart(BranchAddr);
    else if (PCSrc == 2'b10) restart(JumpAddr);
    else if (PCSrc == 2'b11) restart(RsData);
  end

  logic stall_prev = 1'b0;
  always @(posedge Clock) stall_prev = Stall;

  // Monitor: each new ID presentation pops one expected address.
  logic        valid_prev = 1'b0;
  logic [31:0] instr_prev, pc4_prev;
  always @(negedge Clock) begin
    if (!Reset) begin
      valid_prev = 1'b0;
    end else begin
      if (ID_Valid) begin
        if (stall_prev && valid_prev) begin
          check("hold_instr", ID_Instruction, instr_prev);
          check("hold_pc4", ID_PCplus4, pc4_prev);
        end else if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          logic [31:0] a;
          a = exp_q.pop_front();
          exp_q.push_back(exp_q.size() > 0 ? exp_q[$] + 32'd4 : a + 32'd4);
          check("id_instr", ID_Instruction, mem[a[11:2]]);
          check("id_pc4", ID_PCplus4, a + 32'd4);
          delivered++;
        end
      end
      valid_prev = ID_Valid;
      instr_prev = ID_Instruction;
      pc4_prev   = ID_PCplus4;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_valid(input string name, output bit found);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ID_Valid) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int lat;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h11 + 32'(i);
    Reset = 1'b0; PCSrc = 2'b00; BranchAddr = '0; JumpAddr = '0; RsData = '0;
    Stall = 1'b0; Flush = 1'b0; DataRead = 1'b0; DataWrite = 1'b1;
    DataAddr = 32'h0; DataWData = 32'h1234;
    #23;
    check("rst_valid", 32'(ID_Valid), 32'd0);
    check("rst_instr", ID_Instruction, 32'd0);
    check("rst_pc4", ID_PCplus4, 32'd0);
    check("rst_memwrite", 32'(Mem_Write), 32'd0);
    DataWrite = 1'b0;
    #1;
    check("rst_pc", Mem_Address, RESET_PC);
    @(negedge Clock);
    Reset = 1'b1;

    // First-fetch latency from reset.
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ID_Valid) begin
        lat = k;
        break;
      end
    end
    check("first_latency", 32'(lat), 32'(FIRST_LAT));
    repeat (8) step();

    // Stall holds ID while the queue fills, then drains in order.
    Stall = 1'b1;
    repeat (6) step();
    Stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      check("drain_valid", 32'(ID_Valid), 32'd1);
    end

    // Jump with a fetch in flight.
    PCSrc = 2'b10; JumpAddr = 32'h40;
    step();
    PCSrc = 2'b00;
    check("jump_clears_valid", 32'(ID_Valid), 32'd0);
    wait_valid("jump_wait", found);
    check("jump_instr", ID_Instruction, 32'h21);
    check("jump_pc4", ID_PCplus4, 32'h44);

    // Two-cycle data write takes the port.
    DataWrite = 1'b1; DataAddr = 32'h80; DataWData = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("dw_memwrite", 32'(Mem_Write), 32'd1);
      check("dw_addr", Mem_Address, 32'h80);
      check("dw_wdata", Mem_WriteData, 32'hDEAD_BEEF);
      step();
    end
    DataWrite = 1'b0;
    check("dw_stored", mem[32], 32'hDEAD_BEEF);
    repeat (6) step();

    // Redirect coinciding with data reads.
    PCSrc = 2'b01; BranchAddr = 32'h20; DataRead = 1'b1; DataAddr = 32'h900;
    step();
    PCSrc = 2'b00;
    step();
    DataRead = 1'b0;
    repeat (8) step();

    // PC wrap past 2^32.
    PCSrc = 2'b11; RsData = 32'hFFFF_FFF8;
    step();
    PCSrc = 2'b00;
    repeat (8) step();
    PCSrc = 2'b01; BranchAddr = 32'h0;
    step();
    PCSrc = 2'b00;
    repeat (4) step();

    // Reset asserted with the queue full.
    Stall = 1'b1;
    repeat (6) step();
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_valid", 32'(ID_Valid), 32'd0);
    check("midrst_instr", ID_Instruction, 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    Stall = 1'b0;
    wait_valid("midrst_wait", found);
    check("midrst_first", ID_Instruction, mem[RESET_PC[11:2]]);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      Stall = ($urandom_range(3) == 0);
      Flush = ($urandom_range(9) == 0);
      PCSrc = ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      BranchAddr = $urandom & 32'h1FC;
      JumpAddr   = $urandom & 32'h1FC;
      RsData     = $urandom & 32'h1FC;
      if (exp_q.size() > 0 && exp_q[0] > 32'h600) begin
        PCSrc = 2'b01;
        BranchAddr = 32'h0;
      end
      DataRead  = 1'b0;
      DataWrite = 1'b0;
      if ($urandom_range(5) == 0) begin
        if ($urandom_range(1) == 0) DataRead = 1'b1;
        else DataWrite = 1'b1;
      end
      DataAddr  = 32'h800 | ($urandom & 32'h7FC);
      DataWData = $urandom;
      step();
    end
    Stall = 1'b0; Flush = 1'b0; PCSrc = 2'b00; DataRead = 1'b0; DataWrite = 1'b0;
    repeat (10) step();
    check("delivered_enough", 32'(delivered > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
